// File: rtl/tmr_dpr_pkg.sv
// ---------------------------------------------------------------------------
// tmr_dpr_pkg
// Shared types and helpers for the TMR slot fault manager with partial
// reconfiguration.
//   state_t        : fault manager FSM states
//   IDX_NONE       : replica index meaning "no replica"
//   minority_idx() : index of the replica that disagrees with the other two
//   idx_to_mask()  : one-hot replica mask for a replica index
// ---------------------------------------------------------------------------
package tmr_dpr_pkg;

   localparam logic [1:0] IDX_NONE = 2'b11;

   typedef enum logic [2:0] {
      MONITOR   = 3'd0,
      REQUEST   = 3'd1,
      WAIT_DONE = 3'd2,
      RESYNC    = 3'd3,
      FATAL     = 3'd4
   } state_t;

   // With three single-bit replicas, at most one can be the odd one out.
   // If replicas 0 and 1 agree, any disagreement must come from replica 2,
   // and so on.
   function automatic logic [1:0] minority_idx(input logic [2:0] m);
      logic [1:0] idx;
      if ((m[0] == m[1]) && (m[1] == m[2])) begin
         idx = IDX_NONE;
      end else if (m[0] == m[1]) begin
         idx = 2'd2;
      end else if (m[0] == m[2]) begin
         idx = 2'd1;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

   // IDX_NONE maps to an empty mask so callers need no special case.
   function automatic logic [2:0] idx_to_mask(input logic [1:0] idx);
      logic [2:0] mask;
      case (idx)
         2'd0:    mask = 3'b001;
         2'd1:    mask = 3'b010;
         2'd2:    mask = 3'b100;
         default: mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/tmr_dpr_ctrl_minority_detect.sv
// ---------------------------------------------------------------------------
// tmr_minority_detect
// Purely combinational replica comparison logic.
//   mod_out       in  3  replica outputs, bit i from replica i
//   iso_idx       in  2  index of the isolated replica, IDX_NONE if none
//   majority      out 1  2-of-3 majority of mod_out
//   minority      out 2  replica that differs from the other two, or IDX_NONE
//   pair_disagree out 1  the two replicas other than iso_idx differ
//                        (always 0 when nothing is isolated)
// ---------------------------------------------------------------------------
module tmr_minority_detect
   import tmr_dpr_pkg::*;
(
   input  logic [2:0] mod_out,
   input  logic [1:0] iso_idx,
   output logic       majority,
   output logic [1:0] minority,
   output logic       pair_disagree
);

   // Majority and minority are independent of isolation; the FSM decides
   // which of them matters in the current state.
   always_comb begin
      majority = (mod_out[0] & mod_out[1]) |
                 (mod_out[0] & mod_out[2]) |
                 (mod_out[1] & mod_out[2]);
      minority = minority_idx(mod_out);
   end

   // Compare only the two replicas still trusted. With no replica isolated
   // there is no "pair", so no dual disagreement is reported.
   always_comb begin
      pair_disagree = 1'b0;
      case (iso_idx)
         2'd0:    pair_disagree = mod_out[1] ^ mod_out[2];
         2'd1:    pair_disagree = mod_out[0] ^ mod_out[2];
         2'd2:    pair_disagree = mod_out[0] ^ mod_out[1];
         default: pair_disagree = 1'b0;
      endcase
   end

endmodule

// File: rtl/tmr_dpr_ctrl.sv
// ---------------------------------------------------------------------------
// tmr_dpr_ctrl
// Fault manager for a triple-modular-redundant slot with dynamic partial
// reconfiguration. Votes the replicas, filters transient upsets, isolates a
// persistently disagreeing replica, requests its reload, resynchronises and
// releases it, retrying or declaring a fatal fault when recovery fails.
//   clk           in  1  sole clock
//   rst           in  1  synchronous active-high reset
//   mod_out       in  3  replica outputs, bit i from replica i
//   voted         out 1  registered voted result
//   isolate       out 3  one-hot mask of the replica excluded from voting
//   pr_req        out 1  reconfiguration request to the loader
//   pr_id         out 2  replica index being reloaded
//   pr_ack        in  1  loader accepted the request
//   pr_done       in  1  loader finished (1-cycle pulse)
//   pr_err        in  1  loader failed (1-cycle pulse)
//   dual_mismatch out 1  the two non-isolated replicas disagree (registered)
//   fault_count   out 8  successful reloads, saturating at 255
//   fatal         out 1  sticky unrecoverable fault
// ---------------------------------------------------------------------------
module tmr_dpr_ctrl
   import tmr_dpr_pkg::*;
#(
   parameter int MISMATCH_THRESH = 4,
   parameter int PR_TIMEOUT      = 1024,
   parameter int RESYNC_CYCLES   = 16,
   parameter int MAX_RETRIES     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mod_out,
   output logic       voted,
   output logic [2:0] isolate,
   output logic       pr_req,
   output logic [1:0] pr_id,
   input  logic       pr_ack,
   input  logic       pr_done,
   input  logic       pr_err,
   output logic       dual_mismatch,
   output logic [7:0] fault_count,
   output logic       fatal
);

   localparam int MM_W = $clog2(MISMATCH_THRESH + 1);
   localparam int TO_W = $clog2(PR_TIMEOUT + 1);
   localparam int RS_W = $clog2(RESYNC_CYCLES + 1);
   localparam int RT_W = $clog2(MAX_RETRIES + 1);

   localparam logic [MM_W-1:0] MM_LAST = MM_W'(MISMATCH_THRESH - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(PR_TIMEOUT - 1);
   localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESYNC_CYCLES - 1);
   localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

   state_t            state, state_d;
   logic [1:0]        target, target_d;
   logic [2:0]        isolate_d;
   logic              pr_req_d;
   logic [1:0]        pr_id_d;
   logic              voted_d;
   logic              dual_d;
   logic [7:0]        fault_count_d;
   logic              fatal_d;
   logic [MM_W-1:0]   mm_cnt, mm_cnt_d;
   logic [1:0]        mm_idx, mm_idx_d;
   logic [MM_W-1:0]   dm_cnt, dm_cnt_d;
   logic [TO_W-1:0]   to_cnt, to_cnt_d;
   logic [RS_W-1:0]   rs_cnt, rs_cnt_d;
   logic [RT_W-1:0]   retries, retries_d;
   logic [RT_W-1:0]   retries_inc;
   logic              fail;

   logic [1:0]        iso_idx;
   logic              majority;
   logic [1:0]        minority;
   logic              pair_disagree;

   // The isolate mask is only ever zero or the one-hot of target, so the
   // isolated index can be taken straight from target.
   assign iso_idx     = (isolate != 3'b000) ? target : IDX_NONE;
   assign retries_inc = retries + RT_W'(1);

   tmr_minority_detect u_detect (
      .mod_out       (mod_out),
      .iso_idx       (iso_idx),
      .majority      (majority),
      .minority      (minority),
      .pair_disagree (pair_disagree)
   );

   // Next-state and next-output logic. Every register holds by default;
   // each state then overrides what it owns. A failure from any reload
   // stage funnels through one shared retry/fatal decision, and the dual
   // fault watchdog is applied last so it overrides everything outside
   // MONITOR.
   always_comb begin
      state_d       = state;
      target_d      = target;
      isolate_d     = isolate;
      pr_req_d      = pr_req;
      pr_id_d       = pr_id;
      fault_count_d = fault_count;
      fatal_d       = fatal;
      mm_cnt_d      = mm_cnt;
      mm_idx_d      = mm_idx;
      dm_cnt_d      = dm_cnt;
      to_cnt_d      = to_cnt;
      rs_cnt_d      = rs_cnt;
      retries_d     = retries;
      fail          = 1'b0;

      voted_d = (iso_idx == IDX_NONE) ? majority :
                (iso_idx == 2'd0)     ? mod_out[1] : mod_out[0];
      dual_d  = pair_disagree;

      case (state)
         MONITOR: begin
            dm_cnt_d = '0;
            if (minority == IDX_NONE) begin
               mm_cnt_d = '0;
               mm_idx_d = IDX_NONE;
            end else if (minority == mm_idx) begin
               if (mm_cnt == MM_LAST) begin
                  target_d  = minority;
                  isolate_d = idx_to_mask(minority);
                  pr_id_d   = minority;
                  pr_req_d  = 1'b1;
                  retries_d = '0;
                  to_cnt_d  = '0;
                  mm_cnt_d  = '0;
                  mm_idx_d  = IDX_NONE;
                  state_d   = REQUEST;
               end else begin
                  mm_cnt_d = mm_cnt + MM_W'(1);
               end
            end else begin
               mm_cnt_d = MM_W'(1);
               mm_idx_d = minority;
            end
         end

         REQUEST: begin
            to_cnt_d = to_cnt + TO_W'(1);
            if (to_cnt == TO_LAST) begin
               fail = 1'b1;
            end else if (pr_ack) begin
               pr_req_d = 1'b0;
               state_d  = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            to_cnt_d = to_cnt + TO_W'(1);
            if (pr_err || (to_cnt == TO_LAST)) begin
               fail = 1'b1;
            end else if (pr_done) begin
               rs_cnt_d = '0;
               state_d  = RESYNC;
            end
         end

         RESYNC: begin
            rs_cnt_d = rs_cnt + RS_W'(1);
            if (rs_cnt == RS_LAST) begin
               if ((mod_out == 3'b000) || (mod_out == 3'b111)) begin
                  isolate_d = 3'b000;
                  if (fault_count != 8'hFF) begin
                     fault_count_d = fault_count + 8'd1;
                  end
                  mm_cnt_d  = '0;
                  mm_idx_d  = IDX_NONE;
                  retries_d = '0;
                  state_d   = MONITOR;
               end else begin
                  fail = 1'b1;
               end
            end
         end

         FATAL: begin
            fatal_d  = 1'b1;
            pr_req_d = 1'b0;
         end

         default: begin
            state_d = MONITOR;
         end
      endcase

      if (fail) begin
         retries_d = retries_inc;
         if (retries_inc < RT_MAX) begin
            pr_req_d = 1'b1;
            to_cnt_d = '0;
            state_d  = REQUEST;
         end else begin
            pr_req_d = 1'b0;
            fatal_d  = 1'b1;
            state_d  = FATAL;
         end
      end

      if (state != MONITOR) begin
         if (dual_mismatch) begin
            if (dm_cnt == MM_LAST) begin
               pr_req_d = 1'b0;
               fatal_d  = 1'b1;
               state_d  = FATAL;
            end else begin
               dm_cnt_d = dm_cnt + MM_W'(1);
            end
         end else begin
            dm_cnt_d = '0;
         end
      end
   end

   // State register and all output/counter registers. Reset is synchronous
   // and returns everything, including an outstanding pr_req, to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= MONITOR;
         target        <= 2'd0;
         isolate       <= 3'b000;
         pr_req        <= 1'b0;
         pr_id         <= 2'd0;
         voted         <= 1'b0;
         dual_mismatch <= 1'b0;
         fault_count   <= 8'd0;
         fatal         <= 1'b0;
         mm_cnt        <= '0;
         mm_idx        <= IDX_NONE;
         dm_cnt        <= '0;
         to_cnt        <= '0;
         rs_cnt        <= '0;
         retries       <= '0;
      end else begin
         state         <= state_d;
         target        <= target_d;
         isolate       <= isolate_d;
         pr_req        <= pr_req_d;
         pr_id         <= pr_id_d;
         voted         <= voted_d;
         dual_mismatch <= dual_d;
         fault_count   <= fault_count_d;
         fatal         <= fatal_d;
         mm_cnt        <= mm_cnt_d;
         mm_idx        <= mm_idx_d;
         dm_cnt        <= dm_cnt_d;
         to_cnt        <= to_cnt_d;
         rs_cnt        <= rs_cnt_d;
         retries       <= retries_d;
      end
   end

endmodule

// File: doc/tmr_dpr_ctrl.md
# tmr_dpr_ctrl

Sequential fault manager for a triple-modular-redundant slot with dynamic partial reconfiguration (DPR). It samples the three replica outputs, produces a registered voted output, and filters transient single-event upsets (SEUs) with a persistence counter. When one replica disagrees persistently, it isolates that replica and drives a request/ack/done handshake to the partial-reconfiguration loader. After reloading, it resynchronises the replica and releases it, or retries and finally declares a fatal fault.

## Interface
- MISMATCH_THRESH, 4: consecutive cycles of the same minority replica before action; also the dual-mismatch fatal threshold.
- PR_TIMEOUT, 1024: maximum cycles from request entry to `pr_done`/`pr_err`.
- RESYNC_CYCLES, 16: cycles a reloaded replica stays isolated before its agreement check.
- MAX_RETRIES, 2: reload attempts per fault before FATAL.

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- mod_out  in  3  replica outputs; bit i comes from replica i
- voted  out  1  registered voted result
- isolate  out  3  one-hot mask of the replica excluded from voting
- pr_req  out  1  reconfiguration request
- pr_id  out  2  replica index being reloaded
- pr_ack  in  1  loader accepted the request
- pr_done  in  1  loader finished; 1-cycle pulse
- pr_err  in  1  loader failed; 1-cycle pulse
- dual_mismatch  out  1  the two non-isolated replicas disagree (registered)
- fault_count  out  8  completed successful reloads, saturating at 255
- fatal  out  1  sticky unrecoverable fault

## Operation
- **Reset values:** state MONITOR; all outputs 0; internal counters 0; `target` = 0.
- **Voting:**
  - `isolate` = 0: `voted` = majority of `mod_out`.
  - One replica isolated: `voted` = `mod_out` of the lowest-index non-isolated replica.
  - `dual_mismatch` = 1 when the two non-isolated replicas differ.
- **Minority index:** the replica that differs from the other two; "none" if all three agree.
- **MONITOR:**
  - `mm_cnt` increments while the minority index is the same valid value on consecutive cycles.
  - `mm_cnt` clears when all replicas agree or the minority index changes.
  - On the MISMATCH_THRESH-th consecutive sample: set `target` = minority, `isolate[target]` = 1, `pr_id` = `target`, `pr_req` = 1, `retries` = 0, then go to REQUEST.
- **REQUEST:**
  - Hold `pr_req` until `pr_ack` is sampled high, then go to WAIT_DONE; `pr_req` drops on that same edge.
  - The timeout counter clears on every entry to REQUEST and runs through REQUEST and WAIT_DONE.
- **WAIT_DONE:**
  - `pr_done` → RESYNC.
  - `pr_err` or timeout (counter reaches PR_TIMEOUT) → failure path.
  - `pr_err` takes priority over a simultaneous `pr_done`.
  - `pr_done`/`pr_err` are ignored in REQUEST.
- **RESYNC:**
  - Count RESYNC_CYCLES cycles with `target` still isolated.
  - On the last cycle, pass if `mod_out[target]` equals both healthy replicas; otherwise take the failure path.
  - Pass: clear `isolate`, increment `fault_count` (saturating), clear `mm_cnt` and `retries`, return to MONITOR.
- **Failure path:** `retries`++. If `retries` < MAX_RETRIES, re-enter REQUEST and reassert `pr_req`; otherwise go to FATAL.
- **Dual fault:** in any non-MONITOR state, `dual_mismatch` high for MISMATCH_THRESH consecutive cycles → FATAL.
- **FATAL:**
  - `fatal` = 1, `pr_req` = 0.
  - `isolate` holds its value and voting continues.
  - Exits only on `rst`.
- **Reset mid-operation:** synchronous reset returns everything to reset values, including dropping `pr_req` even before `pr_ack`. The loader must tolerate an abandoned request.

## Timing
- `voted` and `dual_mismatch` have 1-cycle latency from `mod_out`.
- Detection: if the first mismatch is sampled at edge N and persists through edge N+THRESH-1, then `isolate`/`pr_req` are high after edge N+THRESH-1. `voted` uses the isolated rule from edge N+THRESH onward.
- `pr_id` is stable whenever `pr_req` is high.
- `pr_ack` in the same cycle `pr_req` first rises is accepted.
- A successful reload releases the replica PR_ACK-latency + done-latency + RESYNC_CYCLES + 1 cycles after the request.
- Timeout: at the earliest, failure is taken on the PR_TIMEOUT-th cycle after entering REQUEST.

## Structure
- Package `tmr_dpr_pkg`:
  - state enum MONITOR/REQUEST/WAIT_DONE/RESYNC/FATAL;
  - constant `IDX_NONE` = 2'b11;
  - function `minority_idx(logic [2:0])`.
- Sub-module `tmr_minority_detect` (combinational): majority, minority index, pairwise-disagree for a given isolated index. Instantiated once.
- Top-level module holds the FSM, counters and output registers.

## Test plan
- All replicas equal, toggling for 100 cycles → `voted` tracks with 1-cycle lag; `isolate` = 0, `pr_req` never asserted.
- `mod_out[1]` inverted for 3 cycles, then agrees → no isolation; `mm_cnt` clears; `fault_count` = 0.
- `mod_out[2]` inverted for 4 cycles; `pr_ack` after 2 cycles; `pr_done` 10 cycles later; replica agrees in RESYNC → `isolate` = 3'b100, `pr_id` = 2; released after 16 resync cycles; `fault_count` = 1.
- Replica 0 faulted; loader returns `pr_err` twice → second REQUEST issued, then FATAL; `fatal` = 1, `isolate` = 3'b001 held.
- No `pr_ack` for 1024 cycles, then `pr_done` together with `pr_err` on retry → timeout counted as a failure, `err` wins, FATAL.
- `rst` asserted while in WAIT_DONE → next cycle all outputs 0, state MONITOR.
